// File: rtl/instruction_fetch.sv
// Fetch stage: drives PC to instruction memory and holds one fetched instruction
// for decode, with stall, redirect flush, halt-opcode stop and a saturating fetch counter.
module instruction_fetch #(
   parameter logic [9:0] RESET_PC    = 10'h000,
   parameter logic [3:0] HALT_OPCODE = 4'hF
) (
   input  logic        clk,
   input  logic        reset,
   output logic [9:0]  PC,
   input  logic [15:0] Instruction,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [9:0]  redirect_target,
   output logic        id_valid,
   output logic [15:0] id_instr,
   output logic [9:0]  id_pc,
   output logic        halted,
   output logic [15:0] fetch_count
);

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   state_t      r_state, w_state_nxt;
   logic [9:0]  r_pc, w_pc_nxt;
   logic        r_id_valid, w_id_valid_nxt;
   logic [15:0] r_id_instr, w_id_instr_nxt;
   logic [9:0]  r_id_pc, w_id_pc_nxt;
   logic [15:0] r_fetch_count, w_fetch_count_nxt;
   logic        w_load;
   logic        w_is_halt;

   // A new word enters the output register only when the slot is empty or draining.
   assign w_load    = (r_state == RUN) && !redirect_valid && (!r_id_valid || id_ready);
   assign w_is_halt = (Instruction[15:12] == HALT_OPCODE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= RUN;
         r_pc          <= RESET_PC;
         r_id_valid    <= 1'b0;
         r_id_instr    <= 16'h0000;
         r_id_pc       <= 10'h000;
         r_fetch_count <= 16'h0000;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_id_valid    <= w_id_valid_nxt;
         r_id_instr    <= w_id_instr_nxt;
         r_id_pc       <= w_id_pc_nxt;
         r_fetch_count <= w_fetch_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_id_valid_nxt    = r_id_valid;
      w_id_instr_nxt    = r_id_instr;
      w_id_pc_nxt       = r_id_pc;
      w_fetch_count_nxt = r_fetch_count;
      if (redirect_valid) begin
         // Flush wins even if decode is accepting this cycle.
         w_pc_nxt       = redirect_target;
         w_id_valid_nxt = 1'b0;
         w_state_nxt    = RUN;
      end else if (w_load) begin
         w_id_instr_nxt    = Instruction;
         w_id_pc_nxt       = r_pc;
         w_id_valid_nxt    = 1'b1;
         w_fetch_count_nxt = (r_fetch_count == 16'hFFFF) ? r_fetch_count : r_fetch_count + 16'd1;
         if (w_is_halt) w_state_nxt = HALTED;
         else           w_pc_nxt    = r_pc + 10'd1;
      end else if (r_id_valid && id_ready) begin
         w_id_valid_nxt = 1'b0;
      end
   end

   assign PC          = r_pc;
   assign id_valid    = r_id_valid;
   assign id_instr    = r_id_instr;
   assign id_pc       = r_id_pc;
   assign halted      = (r_state == HALTED);
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected decode transfers are queued by the
// stimulus and popped by a monitor whenever id_valid && id_ready is presented.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  PC;
   logic [15:0] Instruction;
   logic        id_ready = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [9:0]  redirect_target = 10'h000;
   logic        id_valid;
   logic [15:0] id_instr;
   logic [9:0]  id_pc;
   logic        halted;
   logic [15:0] fetch_count;

   logic [15:0] mem [1024];

   always #5 clk = ~clk;
   assign Instruction = mem[PC];

   instruction_fetch dut (
      .clk(clk), .reset(reset), .PC(PC), .Instruction(Instruction),
      .id_ready(id_ready), .redirect_valid(redirect_valid),
      .redirect_target(redirect_target), .id_valid(id_valid),
      .id_instr(id_instr), .id_pc(id_pc), .halted(halted),
      .fetch_count(fetch_count)
   );

   typedef struct packed {
      logic [15:0] instr;
      logic [9:0]  pc;
   } txn_t;

   txn_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] instr, input logic [9:0] pc);
      txn_t t;
      t.instr = instr;
      t.pc    = pc;
      q.push_back(t);
   endtask

   // Program from address 0 runs four test words, word 4, then halts at word 5.
   task automatic expect_seq();
      push(16'h1001, 10'h000);
      push(16'h2002, 10'h001);
      push(16'h3003, 10'h002);
      push(16'h4004, 10'h003);
      push(16'h0004, 10'h004);
      push(16'hF000, 10'h005);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      redirect_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic drain(input string name, input int maxc);
      int n;
      n = 0;
      while (q.size() != 0 && n < maxc) begin
         @(posedge clk);
         n++;
      end
      chk(name, q.size(), 0);
      q.delete();
   endtask

   task automatic monitor();
      txn_t t;
      forever begin
         @(negedge clk);
         if (!reset && id_valid && id_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_xfer actual id_instr=%0h id_pc=%0h required no transfer", id_instr, id_pc);
            end else begin
               t = q.pop_front();
               chk("xfer_instr", id_instr, t.instr);
               chk("xfer_pc", id_pc, t.pc);
            end
         end
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_pc"}, PC, 10'h000);
      chk({tag, "_valid"}, id_valid, 1'b0);
      chk({tag, "_instr"}, id_instr, 16'h0000);
      chk({tag, "_idpc"}, id_pc, 10'h000);
      chk({tag, "_count"}, fetch_count, 16'h0000);
      chk({tag, "_halted"}, halted, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
      mem[0]      = 16'h1001;
      mem[1]      = 16'h2002;
      mem[2]      = 16'h3003;
      mem[3]      = 16'h4004;
      mem[5]      = 16'hF000;
      mem[10'h100] = 16'h5100;
      mem[10'h3FF] = 16'h1234;

      fork
         monitor();
      join_none

      // Reset state and straight-line fetch ending in halt
      #12 chk_reset_state("rst0");
      @(posedge clk);
      #1 reset = 1'b0;
      expect_seq();
      step(4);
      chk("seq_count4", fetch_count, 16'd4);
      chk("seq_instr4", id_instr, 16'h4004);
      chk("seq_idpc4", id_pc, 10'h003);
      drain("seq_drain", 20);
      step(2);
      chk("halt_flag", halted, 1'b1);
      chk("halt_pc", PC, 10'h005);
      chk("halt_valid", id_valid, 1'b0);
      chk("halt_count", fetch_count, 16'd6);
      step(3);
      chk("halt_pc_hold", PC, 10'h005);
      chk("halt_count_hold", fetch_count, 16'd6);

      // Redirect out of HALTED
      redirect_valid = 1'b1;
      redirect_target = 10'h000;
      step(1);
      redirect_valid = 1'b0;
      chk("unhalt_flag", halted, 1'b0);
      chk("unhalt_valid", id_valid, 1'b0);
      chk("unhalt_pc", PC, 10'h000);
      chk("unhalt_count", fetch_count, 16'd6);
      expect_seq();
      drain("resume_drain", 20);
      step(2);
      chk("rehalt_count", fetch_count, 16'd12);
      chk("rehalt_flag", halted, 1'b1);

      // Stall three cycles while 2002 is held
      id_ready = 1'b1;
      do_reset();
      expect_seq();
      step(2);
      id_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(1);
         chk("stall_instr", id_instr, 16'h2002);
         chk("stall_idpc", id_pc, 10'h001);
         chk("stall_pc", PC, 10'h002);
      end
      id_ready = 1'b1;
      drain("stall_drain", 20);
      step(2);

      // Redirect flush during stall, then wrap from 3FF to 000
      do_reset();
      step(1);
      id_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_target = 10'h100;
      step(1);
      redirect_valid = 1'b0;
      chk("flush_valid", id_valid, 1'b0);
      chk("flush_pc", PC, 10'h100);
      chk("flush_count", fetch_count, 16'd1);
      step(1);
      chk("tgt_valid", id_valid, 1'b1);
      chk("tgt_instr", id_instr, 16'h5100);
      chk("tgt_idpc", id_pc, 10'h100);
      chk("tgt_pc", PC, 10'h101);
      redirect_valid = 1'b1;
      redirect_target = 10'h3FF;
      step(1);
      redirect_valid = 1'b0;
      chk("wrap_pc", PC, 10'h3FF);
      chk("wrap_valid", id_valid, 1'b0);
      push(16'h1234, 10'h3FF);
      expect_seq();
      id_ready = 1'b1;
      drain("wrap_drain", 30);
      step(2);
      chk("wrap_halted", halted, 1'b1);

      // Half-cycle reset during a stall at PC 020
      id_ready = 1'b0;
      do_reset();
      step(1);
      redirect_valid = 1'b1;
      redirect_target = 10'h01F;
      step(1);
      redirect_valid = 1'b0;
      step(1);
      chk("pre_rst_pc", PC, 10'h020);
      chk("pre_rst_instr", id_instr, 16'h001F);
      @(negedge clk);
      reset = 1'b1;
      #1 chk_reset_state("rst_mid");
      @(posedge clk);
      #1 reset = 1'b0;
      id_ready = 1'b1;
      expect_seq();
      drain("post_rst_drain", 20);
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 10'h000, the PC value loaded on reset.
REQ-002 SHALL have parameter HALT_OPCODE, default 4'hF, the Instruction[15:12] value that stops fetching.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port PC  output  10  word address driven to instruction memory.
REQ-006 SHALL have port Instruction  input  16  memory read data for PC, valid combinationally in the same cycle.
REQ-007 SHALL have port id_ready  input  1  decode stage can accept the held instruction this cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump taken; load redirect_target.
REQ-009 SHALL have port redirect_target  input  10  new fetch address.
REQ-010 SHALL have port id_valid  output  1  id_instr/id_pc hold a valid instruction.
REQ-011 SHALL have port id_instr  output  16  fetched instruction to decode.
REQ-012 SHALL have port id_pc  output  10  address of id_instr.
REQ-013 SHALL have port halted  output  1  high in HALTED state.
REQ-014 SHALL have port fetch_count  output  16  instructions loaded into the output register since reset.

Function
REQ-015 SHALL hold PC in a register; the PC port is that register directly, with no combinational path from any input.
REQ-016 SHALL implement states RUN and HALTED; halted = (state == HALTED).
REQ-017 SHALL define load = RUN && !redirect_valid && (!id_valid || id_ready).
REQ-018 On load: id_instr <= Instruction, id_pc <= PC, id_valid <= 1, fetch_count increments; a transfer to decode occurs when id_valid && id_ready.
REQ-019 On load of a non-halt instruction, PC SHALL become PC+1 modulo 1024 (10'h3FF wraps to 10'h000).
REQ-020 On load with Instruction[15:12] == HALT_OPCODE: the halt instruction is still delivered, PC holds its value, state becomes HALTED.
REQ-021 When id_valid && !id_ready, id_valid/id_instr/id_pc and PC SHALL hold unchanged (stall, no instruction lost or duplicated).
REQ-022 When id_valid && id_ready and no load occurs, id_valid SHALL clear to 0 at the next edge.
REQ-023 redirect_valid SHALL take priority over everything: PC <= redirect_target, id_valid <= 0 (flush regardless of id_ready), state <= RUN, fetch_count unchanged.
REQ-024 In HALTED without redirect, PC and fetch_count SHALL hold; only a redirect or reset leaves HALTED.
REQ-025 fetch_count SHALL saturate at 16'hFFFF.
REQ-026 id_instr/id_pc values while id_valid = 0 are don't-care but SHALL NOT be X after reset.

Reset
REQ-027 On reset assertion, immediately and independent of clk: PC = RESET_PC, state = RUN, id_valid = 0, id_instr = 16'h0000, id_pc = 10'h000, fetch_count = 0, halted = 0.
REQ-028 Reset asserted mid-stall or mid-halt SHALL discard the held instruction; first load occurs on the first clk edge after reset deasserts, fetching from RESET_PC.

Verification
REQ-029 Reset, memory words 0..3 = 1001,2002,3003,4004, id_ready = 1 -> id_instr 1001,2002,3003,4004 on consecutive cycles with id_pc 0..3, fetch_count = 4.
REQ-030 id_ready = 0 for 3 cycles while id_instr = 2002 -> id_instr/id_pc/PC stable at 2002/1/2; after id_ready = 1, next id_instr = 3003, no duplicate, no skip.
REQ-031 redirect_valid with target 10'h100 while id_valid = 1, id_ready = 0 -> next cycle id_valid = 0, PC = 10'h100; following cycle id_instr = mem[0x100].
REQ-032 Word 5 = F000 -> F000 delivered with id_pc = 5, halted = 1, PC stays 5, id_valid drops after acceptance; redirect to 10'h000 -> halted = 0, fetching resumes at 0.
REQ-033 redirect_target = 10'h3FF, mem[3FF] = 1234, mem[0] = 1001 -> id_pc sequence 3FF then 000.
REQ-034 Assert reset for half a cycle during a stall at PC = 10'h020 -> all outputs at reset values immediately, first delivered instruction after release has id_pc = RESET_PC.
